mem_access_ctrl: RTL

//  Sequences every memory access of the multicycle CPU: instruction fetch, data load, data store and exception-vector read.

---
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer for the multicycle CPU: fetch, load, store and exception-vector read.
// Drives the IorD select, exception vector, memory/IR/MDR/EPC strobes and a one-cycle done pulse.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        load_req,
  input  logic        store_req,
  input  logic        addr_src,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  output logic [1:0]  iord_sel,
  output logic [31:0] exc_vec,
  output logic        mem_wr,
  output logic        ir_wr,
  output logic        mdr_wr,
  output logic        epc_wr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  // Handshake: fetch/load/store are levels held by the master until it sees
  // done; exc_req is a pulse that is remembered if it cannot be taken at once.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2,
    K_EXC   = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  pcode_q, pcode_d;
  logic [1:0]  iord_q, iord_d;
  logic [31:0] vec_q, vec_d;
  logic        mem_wr_q, ir_wr_q, mdr_wr_q, epc_wr_q, busy_q, done_q;
  logic        exc_take, epc_take;
  logic [1:0]  take_code;

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pcode_d   = pcode_q;
    iord_d    = iord_q;
    vec_d     = vec_q;
    epc_take  = 1'b0;
    exc_take  = pend_q | (exc_req & (state_q == IDLE));
    take_code = (exc_req && (state_q == IDLE)) ? exc_code : pcode_q;

    case (state_q)
      // FINISH accepts like IDLE so back-to-back accesses have no bubble.
      IDLE, FINISH: begin
        state_d = IDLE;
        if (exc_take) begin
          state_d  = ACCESS;
          kind_d   = K_EXC;
          iord_d   = 2'b11;
          vec_d    = (take_code == 2'd3) ? 32'd253 : (32'd253 + {30'd0, take_code});
          epc_take = 1'b1;
          pend_d   = 1'b0;
        end else if (store_req) begin
          state_d = ACCESS;
          kind_d  = K_STORE;
          iord_d  = addr_src ? 2'b10 : 2'b01;
        end else if (load_req) begin
          state_d = ACCESS;
          kind_d  = K_LOAD;
          iord_d  = addr_src ? 2'b10 : 2'b01;
        end else if (fetch_req) begin
          state_d = ACCESS;
          kind_d  = K_FETCH;
          iord_d  = 2'b00;
        end
      end
      ACCESS: begin
        if (kind_q == K_STORE) begin
          state_d = FINISH;
        end else begin
          cnt_d   = 3'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) state_d = FINISH;
        else               cnt_d   = cnt_q - 3'd1;
      end
    endcase

    // Anything not taken directly from IDLE is parked; the newest code wins.
    if (exc_req && (state_q != IDLE)) begin
      pend_d  = 1'b1;
      pcode_d = exc_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= K_FETCH;
      cnt_q    <= 3'd0;
      pend_q   <= 1'b0;
      pcode_q  <= 2'd0;
      iord_q   <= 2'b00;
      vec_q    <= 32'd0;
      mem_wr_q <= 1'b0;
      ir_wr_q  <= 1'b0;
      mdr_wr_q <= 1'b0;
      epc_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pcode_q  <= pcode_d;
      iord_q   <= iord_d;
      vec_q    <= vec_d;
      mem_wr_q <= (state_d == ACCESS) && (kind_d == K_STORE);
      ir_wr_q  <= (state_d == FINISH) && (kind_d == K_FETCH);
      mdr_wr_q <= (state_d == FINISH) && ((kind_d == K_LOAD) || (kind_d == K_EXC));
      epc_wr_q <= epc_take;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FINISH);
    end
  end

  assign iord_sel  = iord_q;
  assign exc_vec   = vec_q;
  assign mem_wr    = mem_wr_q;
  assign ir_wr     = ir_wr_q;
  assign mdr_wr    = mdr_wr_q;
  assign epc_wr    = epc_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
